fp_writeback_csr: RTL and testbench
===================================

Name: fp_writeback_csr

Overview:
- Sits directly downstream of the floating-point execute stage.
- Registers the FP execute result into the EX/WB pipeline register, which drives the FP register-file write port and the WB forwarding source.
- Owns the architectural fcsr (fflags accrued-exception bits and the frm dynamic rounding mode).
- Serves Zicsr accesses to fflags/frm/fcsr and resolves the per-instruction rounding mode supplied to the execute stage.

Parameters:
FLEN, 32, FP data width
XLEN, 32, integer/CSR data width

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_ex_flush  input  1  kill EX instruction (bubble into WB, no CSR/flag side effects)
i_stall  input  1  hold EX/WB register and fcsr
i_ex_rd  input  5  destination register of EX instruction
i_fp_result  input  FLEN  FP execute result
i_fp_reg_write  input  1  EX instruction writes FP RF
i_fflags  input  5  exception flags from FP execute {NV,DZ,OF,UF,NX}
i_fflags_valid  input  1  EX instruction is an FP arithmetic op that accrues flags
i_instr_rm  input  3  rm field of the instruction in ID
i_csr_en  input  1  EX instruction is a CSR access
i_csr_op  input  2  funct3[1:0]: 01 RW, 10 RS, 11 RC
i_csr_addr  input  12  CSR address
i_csr_wdata  input  XLEN  rs1 value or zero-extended uimm
o_csr_hit  output  1  i_csr_addr is 0x001/0x002/0x003 and i_csr_en
o_csr_rdata  output  XLEN  old CSR value, zero when ~o_csr_hit
o_eff_frm  output  3  resolved rounding mode for ID instruction
o_illegal_rm  output  1  resolved rounding mode is reserved
o_fcsr  output  8  {frm, fflags} architectural state
o_wb_rd  output  5  WB destination register
o_wb_fp_rd_din  output  FLEN  WB write data (FP RF + forwarding)
o_wb_fp_reg_write  output  1  WB FP RF write enable

Behaviour:
- Reset, asynchronous on i_rst_n low, including mid-operation: o_wb_rd=0, o_wb_fp_rd_din=0, o_wb_fp_reg_write=0, fflags=0, frm=0 (RNE). o_fcsr=0.
- Latency: EX inputs appear on o_wb_* 1 cycle after the capturing edge.
- Priority at each posedge is stall > flush > normal.
- i_stall: EX/WB register and fcsr hold, even if i_ex_flush is also high.
- i_ex_flush (no stall): o_wb_fp_reg_write<=0, o_wb_rd<=0, o_wb_fp_rd_din<=0. No flag accrual, no CSR write.
- Normal: capture i_ex_rd, i_fp_result, i_fp_reg_write.
- CSR read: combinational, returns pre-edge state.
  - 0x001 -> {27'b0,fflags}
  - 0x002 -> {29'b0,frm}
  - 0x003 -> {24'b0,frm,fflags}
  - Bits above a field ignore writes.
- CSR write on a normal edge with o_csr_hit:
  - RW: new = wdata.
  - RS: new = old | wdata.
  - RC: new = old & ~wdata.
  - Applied only to the addressed field(s). fcsr uses wdata[7:5] for frm and wdata[4:0] for fflags.
- Accrual on a normal edge with i_fflags_valid: fflags_next = fflags_after_csr | i_fflags. Flags are sticky and cleared only by a CSR write or reset.
- Simultaneous CSR write and accrual: the CSR write is applied first, then i_fflags is ORed in.
- o_eff_frm = (i_instr_rm==3'b111) ? frm : i_instr_rm. Combinational on current registered frm; no bypass of a CSR write in flight (the pipeline interlocks).
- o_illegal_rm = o_eff_frm is 101, 110 or 111. This includes the case of dynamic rm with a stored frm of 101–111.
- frm accepts any 3-bit value; illegality is flagged only at use.
- o_csr_hit and o_csr_rdata are purely combinational; o_csr_rdata=0 when not hit.

Decomposition:
- Shared package fp_pkg holds:
  - CSR addresses CSR_FFLAGS=12'h001, CSR_FRM=12'h002, CSR_FCSR=12'h003.
  - CSR op encodings CSR_RW/RS/RC.
  - Rounding-mode constants RM_RNE..RM_RMM, RM_DYN=3'b111.
  - Flag bit indices.
  - Packed typedef pipe_ex_wb_fp {rd, fp_result, fp_reg_write}.
- One sub-module, fp_csr_file: fcsr state, read mux, write/accrual logic, rm resolution.
- The top holds the EX/WB register and stall/flush gating.

Test Plan:
- Reset release, then i_fp_result=32'h3F800000, rd=5, reg_write=1 -> next cycle o_wb_fp_rd_din=3F800000, o_wb_rd=5, o_wb_fp_reg_write=1; o_fcsr=0.
- Two accruals: i_fflags=5'b00001 then 5'b10000 (valid) -> fflags=5'b10001. CSR RS 0x001 with wdata 0 -> o_csr_rdata=0x11, state unchanged.
- CSR RW 0x003 wdata=0xFF -> rdata returns old value; afterwards o_fcsr=8'hFF. RC 0x001 wdata=0x1F -> o_fcsr=8'hE0.
- Same edge: RW 0x001 wdata=0 with i_fflags_valid, i_fflags=5'b00100 -> fflags=5'b00100.
- Flush with valid flags 5'b11111 and reg_write=1 -> no accrual, o_wb_fp_reg_write=0. Stall+flush -> all outputs hold.
- frm=3'b001, i_instr_rm=111 -> o_eff_frm=001, illegal=0. frm=101, rm=111 -> illegal=1. rm=110 -> illegal=1. Assert i_rst_n low mid-sequence -> all outputs zero immediately.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared FP writeback/CSR constants, payload types and CSR read-modify-write helper.
package fp_pkg;

   localparam int unsigned FLEN     = 32;
   localparam int unsigned XLEN     = 32;
   localparam int unsigned RD_W     = 5;
   localparam int unsigned FFLAGS_W = 5;
   localparam int unsigned FRM_W    = 3;
   localparam int unsigned FCSR_W   = FFLAGS_W + FRM_W;

   localparam logic [11:0] CSR_FFLAGS = 12'h001;
   localparam logic [11:0] CSR_FRM    = 12'h002;
   localparam logic [11:0] CSR_FCSR   = 12'h003;

   localparam logic [1:0] CSR_RW = 2'b01;
   localparam logic [1:0] CSR_RS = 2'b10;
   localparam logic [1:0] CSR_RC = 2'b11;

   localparam logic [2:0] RM_RNE = 3'b000;
   localparam logic [2:0] RM_RTZ = 3'b001;
   localparam logic [2:0] RM_RDN = 3'b010;
   localparam logic [2:0] RM_RUP = 3'b011;
   localparam logic [2:0] RM_RMM = 3'b100;
   localparam logic [2:0] RM_DYN = 3'b111;

   localparam int unsigned FLAG_NX = 0;
   localparam int unsigned FLAG_UF = 1;
   localparam int unsigned FLAG_OF = 2;
   localparam int unsigned FLAG_DZ = 3;
   localparam int unsigned FLAG_NV = 4;

   typedef struct packed {
      logic [RD_W-1:0] rd;
      logic [FLEN-1:0] fp_result;
      logic            fp_reg_write;
   } pipe_ex_wb_fp;

   // Zicsr read-modify-write on the fcsr-sized window; unknown op leaves the value unchanged.
   function automatic logic [FCSR_W-1:0] csr_alu(input logic [1:0]        op,
                                                 input logic [FCSR_W-1:0] old_v,
                                                 input logic [FCSR_W-1:0] wdata);
      logic [FCSR_W-1:0] res;
      case (op)
         CSR_RW:  res = wdata;
         CSR_RS:  res = old_v | wdata;
         CSR_RC:  res = old_v & ~wdata;
         default: res = old_v;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/fp_csr_file.sv
// Architectural fcsr: fflags/frm state, Zicsr read/write, flag accrual and rm resolution.
module fp_csr_file
   import fp_pkg::*;
(
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_update,
   input  logic                i_csr_en,
   input  logic [1:0]          i_csr_op,
   input  logic [11:0]         i_csr_addr,
   input  logic [XLEN-1:0]     i_csr_wdata,
   input  logic [FFLAGS_W-1:0] i_fflags,
   input  logic                i_fflags_valid,
   input  logic [FRM_W-1:0]    i_instr_rm,
   output logic                o_csr_hit,
   output logic [XLEN-1:0]     o_csr_rdata,
   output logic [FRM_W-1:0]    o_eff_frm,
   output logic                o_illegal_rm,
   output logic [FCSR_W-1:0]   o_fcsr
);

   logic [FFLAGS_W-1:0] fflags_q, fflags_d;
   logic [FRM_W-1:0]    frm_q, frm_d;
   logic [FCSR_W-1:0]   old_win;
   logic [FCSR_W-1:0]   new_win;
   logic                unused_wdata;

   // Only the low fcsr-wide slice of the write data can reach a field.
   assign unused_wdata = ^i_csr_wdata[XLEN-1:FCSR_W];

   assign o_csr_hit = i_csr_en &&
                      (i_csr_addr == CSR_FFLAGS || i_csr_addr == CSR_FRM || i_csr_addr == CSR_FCSR);

   // Read mux: old value of the addressed CSR, right-aligned and zero-extended.
   always_comb begin
      old_win = '0;
      case (i_csr_addr)
         CSR_FFLAGS: old_win = FCSR_W'(fflags_q);
         CSR_FRM:    old_win = FCSR_W'(frm_q);
         CSR_FCSR:   old_win = {frm_q, fflags_q};
         default:    old_win = '0;
      endcase
   end

   assign o_csr_rdata = o_csr_hit ? XLEN'(old_win) : '0;
   assign new_win     = csr_alu(i_csr_op, old_win, i_csr_wdata[FCSR_W-1:0]);

   // Next fcsr: CSR write to the addressed field(s) first, then sticky flag accrual on top.
   always_comb begin
      fflags_d = fflags_q;
      frm_d    = frm_q;
      if (i_update && o_csr_hit) begin
         case (i_csr_addr)
            CSR_FFLAGS: fflags_d = new_win[FFLAGS_W-1:0];
            CSR_FRM:    frm_d    = new_win[FRM_W-1:0];
            CSR_FCSR: begin
               frm_d    = new_win[FCSR_W-1:FFLAGS_W];
               fflags_d = new_win[FFLAGS_W-1:0];
            end
            default: ;
         endcase
      end
      if (i_update && i_fflags_valid) begin
         fflags_d = fflags_d | i_fflags;
      end
   end

   // fcsr state register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         fflags_q <= '0;
         frm_q    <= RM_RNE;
      end else begin
         fflags_q <= fflags_d;
         frm_q    <= frm_d;
      end
   end

   // Dynamic rm reads the committed frm; the pipeline interlocks against in-flight frm writes.
   assign o_eff_frm    = (i_instr_rm == RM_DYN) ? frm_q : i_instr_rm;
   assign o_illegal_rm = o_eff_frm[2] & (o_eff_frm[1] | o_eff_frm[0]);
   assign o_fcsr       = {frm_q, fflags_q};

endmodule

// File: rtl/fp_writeback_csr.sv
// FP EX/WB pipeline register with stall/flush gating, plus the fcsr owner.
module fp_writeback_csr
   import fp_pkg::*;
(
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_ex_flush,
   input  logic                i_stall,
   input  logic [RD_W-1:0]     i_ex_rd,
   input  logic [FLEN-1:0]     i_fp_result,
   input  logic                i_fp_reg_write,
   input  logic [FFLAGS_W-1:0] i_fflags,
   input  logic                i_fflags_valid,
   input  logic [FRM_W-1:0]    i_instr_rm,
   input  logic                i_csr_en,
   input  logic [1:0]          i_csr_op,
   input  logic [11:0]         i_csr_addr,
   input  logic [XLEN-1:0]     i_csr_wdata,
   output logic                o_csr_hit,
   output logic [XLEN-1:0]     o_csr_rdata,
   output logic [FRM_W-1:0]    o_eff_frm,
   output logic                o_illegal_rm,
   output logic [FCSR_W-1:0]   o_fcsr,
   output logic [RD_W-1:0]     o_wb_rd,
   output logic [FLEN-1:0]     o_wb_fp_rd_din,
   output logic                o_wb_fp_reg_write
);

   pipe_ex_wb_fp pipe_q, pipe_d;
   logic         update;

   // CSR writes and flag accrual only happen on a normal (non-stalled, non-flushed) edge.
   assign update = ~i_stall & ~i_ex_flush;

   // EX/WB next value: stall holds, flush inserts a bubble, otherwise capture EX.
   always_comb begin
      pipe_d = pipe_q;
      if (!i_stall) begin
         if (i_ex_flush) begin
            pipe_d = '0;
         end else begin
            pipe_d.rd           = i_ex_rd;
            pipe_d.fp_result    = i_fp_result;
            pipe_d.fp_reg_write = i_fp_reg_write;
         end
      end
   end

   // EX/WB pipeline register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pipe_q <= '0;
      end else begin
         pipe_q <= pipe_d;
      end
   end

   assign o_wb_rd           = pipe_q.rd;
   assign o_wb_fp_rd_din    = pipe_q.fp_result;
   assign o_wb_fp_reg_write = pipe_q.fp_reg_write;

   fp_csr_file u_csr (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .i_update       (update),
      .i_csr_en       (i_csr_en),
      .i_csr_op       (i_csr_op),
      .i_csr_addr     (i_csr_addr),
      .i_csr_wdata    (i_csr_wdata),
      .i_fflags       (i_fflags),
      .i_fflags_valid (i_fflags_valid),
      .i_instr_rm     (i_instr_rm),
      .o_csr_hit      (o_csr_hit),
      .o_csr_rdata    (o_csr_rdata),
      .o_eff_frm      (o_eff_frm),
      .o_illegal_rm   (o_illegal_rm),
      .o_fcsr         (o_fcsr)
   );

endmodule

// File: tb/tb_fp_writeback_csr.sv
// Directed vector bench for fp_writeback_csr.
module tb_fp_writeback_csr;

   logic        i_clk;
   logic        i_rst_n;
   logic        i_ex_flush;
   logic        i_stall;
   logic [4:0]  i_ex_rd;
   logic [31:0] i_fp_result;
   logic        i_fp_reg_write;
   logic [4:0]  i_fflags;
   logic        i_fflags_valid;
   logic [2:0]  i_instr_rm;
   logic        i_csr_en;
   logic [1:0]  i_csr_op;
   logic [11:0] i_csr_addr;
   logic [31:0] i_csr_wdata;
   logic        o_csr_hit;
   logic [31:0] o_csr_rdata;
   logic [2:0]  o_eff_frm;
   logic        o_illegal_rm;
   logic [7:0]  o_fcsr;
   logic [4:0]  o_wb_rd;
   logic [31:0] o_wb_fp_rd_din;
   logic        o_wb_fp_reg_write;

   int n_vec  = 0;
   int n_fail = 0;

   fp_writeback_csr dut (
      .i_clk             (i_clk),
      .i_rst_n           (i_rst_n),
      .i_ex_flush        (i_ex_flush),
      .i_stall           (i_stall),
      .i_ex_rd           (i_ex_rd),
      .i_fp_result       (i_fp_result),
      .i_fp_reg_write    (i_fp_reg_write),
      .i_fflags          (i_fflags),
      .i_fflags_valid    (i_fflags_valid),
      .i_instr_rm        (i_instr_rm),
      .i_csr_en          (i_csr_en),
      .i_csr_op          (i_csr_op),
      .i_csr_addr        (i_csr_addr),
      .i_csr_wdata       (i_csr_wdata),
      .o_csr_hit         (o_csr_hit),
      .o_csr_rdata       (o_csr_rdata),
      .o_eff_frm         (o_eff_frm),
      .o_illegal_rm      (o_illegal_rm),
      .o_fcsr            (o_fcsr),
      .o_wb_rd           (o_wb_rd),
      .o_wb_fp_rd_din    (o_wb_fp_rd_din),
      .o_wb_fp_reg_write (o_wb_fp_reg_write)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct {
      logic        stall;
      logic        flush;
      logic [4:0]  rd;
      logic [31:0] res;
      logic        we;
      logic [4:0]  ff;
      logic        fv;
      logic [2:0]  rm;
      logic        cen;
      logic [1:0]  op;
      logic [11:0] addr;
      logic [31:0] wd;
      logic        e_hit;
      logic [31:0] e_rdata;
      logic [2:0]  e_frm;
      logic        e_ill;
      logic [7:0]  e_fcsr;
      logic [4:0]  e_rd;
      logic [31:0] e_din;
      logic        e_we;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " wb_we"},  32'(o_wb_fp_reg_write), 32'h0);
      chk({tag, " wb_rd"},  32'(o_wb_rd),           32'h0);
      chk({tag, " wb_din"}, o_wb_fp_rd_din,         32'h0);
      chk({tag, " fcsr"},   32'(o_fcsr),            32'h0);
   endtask

   task automatic idle_inputs();
      i_stall = 1'b0; i_ex_flush = 1'b0; i_ex_rd = 5'd0; i_fp_result = 32'h0;
      i_fp_reg_write = 1'b0; i_fflags = 5'd0; i_fflags_valid = 1'b0; i_instr_rm = 3'd0;
      i_csr_en = 1'b0; i_csr_op = 2'b00; i_csr_addr = 12'h000; i_csr_wdata = 32'h0;
   endtask

   initial begin
      // stall flush rd res we | ff fv rm | cen op addr wd || hit rdata efrm ill | fcsr rd din we
      vq.push_back('{1'b0,1'b0,5'd5,32'h3F800000,1'b1, 5'h00,1'b0,3'd0, 1'b0,2'b00,12'h000,32'h0,
                     1'b0,32'h0,3'd0,1'b0, 8'h00,5'd5,32'h3F800000,1'b1});
      vq.push_back('{1'b0,1'b0,5'd0,32'h0,1'b0, 5'h01,1'b1,3'd0, 1'b0,2'b00,12'h000,32'h0,
                     1'b0,32'h0,3'd0,1'b0, 8'h01,5'd0,32'h0,1'b0});
      vq.push_back('{1'b0,1'b0,5'd0,32'h0,1'b0, 5'h10,1'b1,3'd0, 1'b0,2'b00,12'h000,32'h0,
                     1'b0,32'h0,3'd0,1'b0, 8'h11,5'd0,32'h0,1'b0});
      vq.push_back('{1'b0,1'b0,5'd0,32'h0,1'b0, 5'h00,1'b0,3'd0, 1'b1,2'b10,12'h001,32'h0,
                     1'b1,32'h11,3'd0,1'b0, 8'h11,5'd0,32'h0,1'b0});
      vq.push_back('{1'b0,1'b0,5'd0,32'h0,1'b0, 5'h00,1'b0,3'd0, 1'b1,2'b01,12'h003,32'hFF,
                     1'b1,32'h11,3'd0,1'b0, 8'hFF,5'd0,32'h0,1'b0});
      vq.push_back('{1'b0,1'b0,5'd0,32'h0,1'b0, 5'h00,1'b0,3'd7, 1'b1,2'b10,12'h002,32'h0,
                     1'b1,32'h7,3'd7,1'b1, 8'hFF,5'd0,32'h0,1'b0});
      vq.push_back('{1'b0,1'b0,5'd0,32'h0,1'b0, 5'h00,1'b0,3'd0, 1'b1,2'b11,12'h001,32'h1F,
                     1'b1,32'h1F,3'd0,1'b0, 8'hE0,5'd0,32'h0,1'b0});
      vq.push_back('{1'b0,1'b0,5'd3,32'h12345678,1'b1, 5'h04,1'b1,3'd0, 1'b1,2'b01,12'h001,32'h0,
                     1'b1,32'h0,3'd0,1'b0, 8'hE4,5'd3,32'h12345678,1'b1});
      vq.push_back('{1'b0,1'b1,5'd9,32'hDEADBEEF,1'b1, 5'h1F,1'b1,3'd0, 1'b1,2'b01,12'h003,32'h0,
                     1'b1,32'hE4,3'd0,1'b0, 8'hE4,5'd0,32'h0,1'b0});
      vq.push_back('{1'b0,1'b0,5'd7,32'hCAFEF00D,1'b1, 5'h00,1'b0,3'd0, 1'b0,2'b00,12'h000,32'h0,
                     1'b0,32'h0,3'd0,1'b0, 8'hE4,5'd7,32'hCAFEF00D,1'b1});
      vq.push_back('{1'b1,1'b1,5'd1,32'h1,1'b0, 5'h1F,1'b1,3'd0, 1'b1,2'b01,12'h003,32'h0,
                     1'b1,32'hE4,3'd0,1'b0, 8'hE4,5'd7,32'hCAFEF00D,1'b1});
      vq.push_back('{1'b1,1'b0,5'd2,32'h2,1'b1, 5'h1F,1'b1,3'd0, 1'b0,2'b00,12'h000,32'h0,
                     1'b0,32'h0,3'd0,1'b0, 8'hE4,5'd7,32'hCAFEF00D,1'b1});
      vq.push_back('{1'b0,1'b0,5'd0,32'h0,1'b0, 5'h00,1'b0,3'd7, 1'b1,2'b01,12'h002,32'h1,
                     1'b1,32'h7,3'd7,1'b1, 8'h24,5'd0,32'h0,1'b0});
      vq.push_back('{1'b0,1'b0,5'd0,32'h0,1'b0, 5'h00,1'b0,3'd7, 1'b1,2'b01,12'h002,32'h5,
                     1'b1,32'h1,3'd1,1'b0, 8'hA4,5'd0,32'h0,1'b0});
      vq.push_back('{1'b0,1'b0,5'd0,32'h0,1'b0, 5'h00,1'b0,3'd7, 1'b0,2'b00,12'h000,32'h0,
                     1'b0,32'h0,3'd5,1'b1, 8'hA4,5'd0,32'h0,1'b0});
      vq.push_back('{1'b0,1'b0,5'd0,32'h0,1'b0, 5'h00,1'b0,3'd6, 1'b0,2'b00,12'h000,32'h0,
                     1'b0,32'h0,3'd6,1'b1, 8'hA4,5'd0,32'h0,1'b0});
      vq.push_back('{1'b0,1'b0,5'd0,32'h0,1'b0, 5'h00,1'b0,3'd4, 1'b0,2'b00,12'h000,32'h0,
                     1'b0,32'h0,3'd4,1'b0, 8'hA4,5'd0,32'h0,1'b0});
      vq.push_back('{1'b0,1'b0,5'd0,32'h0,1'b0, 5'h00,1'b0,3'd0, 1'b1,2'b01,12'h004,32'hFF,
                     1'b0,32'h0,3'd0,1'b0, 8'hA4,5'd0,32'h0,1'b0});
      vq.push_back('{1'b0,1'b0,5'd0,32'h0,1'b0, 5'h00,1'b0,3'd0, 1'b0,2'b01,12'h003,32'h0,
                     1'b0,32'h0,3'd0,1'b0, 8'hA4,5'd0,32'h0,1'b0});
      vq.push_back('{1'b0,1'b0,5'd0,32'h0,1'b0, 5'h00,1'b0,3'd0, 1'b1,2'b01,12'h003,32'hFFFFFF1B,
                     1'b1,32'hA4,3'd0,1'b0, 8'h1B,5'd0,32'h0,1'b0});
      vq.push_back('{1'b0,1'b0,5'd0,32'h0,1'b0, 5'h00,1'b0,3'd7, 1'b1,2'b10,12'h002,32'h4,
                     1'b1,32'h0,3'd0,1'b0, 8'h9B,5'd0,32'h0,1'b0});
      vq.push_back('{1'b0,1'b0,5'd0,32'h0,1'b0, 5'h04,1'b1,3'd0, 1'b1,2'b11,12'h003,32'h80,
                     1'b1,32'h9B,3'd0,1'b0, 8'h1F,5'd0,32'h0,1'b0});
      vq.push_back('{1'b0,1'b0,5'd31,32'hFFFFFFFF,1'b1, 5'h00,1'b0,3'd7, 1'b0,2'b00,12'h000,32'h0,
                     1'b0,32'h0,3'd0,1'b0, 8'h1F,5'd31,32'hFFFFFFFF,1'b1});

      idle_inputs();
      i_rst_n = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      chk_all_zero("reset");

      @(negedge i_clk);
      i_rst_n = 1'b1;

      for (int i = 0; i < vq.size(); i++) begin
         vec_t v;
         v = vq[i];
         @(negedge i_clk);
         i_stall = v.stall;   i_ex_flush = v.flush;  i_ex_rd = v.rd;
         i_fp_result = v.res; i_fp_reg_write = v.we; i_fflags = v.ff;
         i_fflags_valid = v.fv; i_instr_rm = v.rm;   i_csr_en = v.cen;
         i_csr_op = v.op;     i_csr_addr = v.addr;   i_csr_wdata = v.wd;
         #1;
         chk($sformatf("v%0d csr_hit", i),    32'(o_csr_hit),    32'(v.e_hit));
         chk($sformatf("v%0d csr_rdata", i),  o_csr_rdata,       v.e_rdata);
         chk($sformatf("v%0d eff_frm", i),    32'(o_eff_frm),    32'(v.e_frm));
         chk($sformatf("v%0d illegal_rm", i), 32'(o_illegal_rm), 32'(v.e_ill));
         @(posedge i_clk);
         #1;
         chk($sformatf("v%0d fcsr", i),   32'(o_fcsr),            32'(v.e_fcsr));
         chk($sformatf("v%0d wb_rd", i),  32'(o_wb_rd),           32'(v.e_rd));
         chk($sformatf("v%0d wb_din", i), o_wb_fp_rd_din,         v.e_din);
         chk($sformatf("v%0d wb_we", i),  32'(o_wb_fp_reg_write), 32'(v.e_we));
      end

      // Asynchronous reset mid-cycle with live WB contents and nonzero fcsr.
      #2;
      i_rst_n = 1'b0;
      #1;
      chk_all_zero("async_rst");

      // After release, dynamic rm must resolve to the reset frm (RNE) and state stays cleared.
      @(negedge i_clk);
      idle_inputs();
      i_instr_rm = 3'd7;
      i_rst_n = 1'b1;
      #1;
      chk("post_rst eff_frm",    32'(o_eff_frm),    32'h0);
      chk("post_rst illegal_rm", 32'(o_illegal_rm), 32'h0);
      @(posedge i_clk);
      #1;
      chk_all_zero("post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   // Absolute watchdog so the bench always terminates.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
